rst_seq_ctrl: RTL and testbench
===============================

RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 The block SHALL expose these parameters: PLL_RST_CYC (default 16) = PLL reset pulse length, in cycles.
REQ-002 LOCK_TIMEOUT_CYC (default 50000) SHALL be the maximum wait for lock.
REQ-003 LOCK_STABLE_CYC (default 1000) SHALL be the number of consecutive locked cycles required before releasing SDRAM.
REQ-004 INIT_TIMEOUT_CYC (default 65535) SHALL be the maximum wait for SDRAM init done.
REQ-005 LCD_DELAY_CYC (default 100) SHALL be the LCD reset release-to-ready delay.
REQ-006 MAX_RETRY (default 3, range 1..15) SHALL be the number of failed attempts that leads to FAULT.
REQ-007 Port clk  in  1  SHALL be the free-running 50 MHz board clock, not a PLL output; it is the single clock.
REQ-008 Port rst_n  in  1  SHALL be the synchronous, active-low reset, sampled on the clk rising edge.
REQ-009 Port pll_locked  in  1  SHALL be the PLL LOCKED signal, asynchronous to clk.
REQ-010 Port sdram_init_done  in  1  SHALL be the SDRAM controller init-complete flag, asynchronous to clk, level.
REQ-011 Port pll_rst  out  1  SHALL be the active-high reset to the PLL.
REQ-012 Port sdram_rst_n  out  1  SHALL be the active-low reset to the SDRAM controller.
REQ-013 Port lcd_rst_n  out  1  SHALL be the active-low reset to the LCD timing logic.
REQ-014 Port sys_ready  out  1  SHALL indicate that the full sequence is complete.
REQ-015 Port retry_cnt  out  4  SHALL count failed attempts, saturating at 15.
REQ-016 Port fault  out  1  SHALL be a sticky failure flag.

Function
REQ-017 pll_locked and sdram_init_done SHALL each pass through a 2-flop synchronizer (flops reset to 0) before use, giving lock_s and done_s; latency is 2 cycles.
REQ-018 All outputs SHALL be registered and SHALL take the values of the state entered on the same clk edge as the state change.
REQ-019 States SHALL be PLL_RST, WAIT_LOCK, STABLE, SDRAM_INIT, LCD_REL, READY and FAULT.
REQ-020 A 17-bit cycle counter SHALL clear on every state entry, increment once per cycle in the state, and never wrap (all limits are < 2^17).
REQ-021 Output encoding per state:
- PLL_RST: pll_rst=1, sdram_rst_n=0, lcd_rst_n=0, sys_ready=0
- WAIT_LOCK and STABLE: pll_rst=0, other outputs as in PLL_RST
- SDRAM_INIT: sdram_rst_n=1
- LCD_REL: sdram_rst_n=1, lcd_rst_n=1
- READY: sdram_rst_n=1, lcd_rst_n=1, sys_ready=1
- FAULT: pll_rst=1, all resets asserted, sys_ready=0, fault=1
REQ-022 PLL_RST SHALL last exactly PLL_RST_CYC cycles and then go to WAIT_LOCK.
REQ-023 WAIT_LOCK SHALL go to STABLE when lock_s=1.
REQ-024 If lock_s has not risen after LOCK_TIMEOUT_CYC cycles, WAIT_LOCK SHALL take the retry path; if lock_s=1 in the timeout cycle, lock SHALL win.
REQ-025 STABLE SHALL go to SDRAM_INIT after LOCK_STABLE_CYC consecutive cycles of lock_s=1.
REQ-026 If lock_s=0 in any STABLE cycle, the block SHALL return to WAIT_LOCK with no retry increment.
REQ-027 SDRAM_INIT SHALL go to LCD_REL when done_s=1.
REQ-028 If done_s is not seen after INIT_TIMEOUT_CYC cycles, SDRAM_INIT SHALL take the retry path; if done_s=1 in the timeout cycle, done SHALL win.
REQ-029 LCD_REL SHALL last exactly LCD_DELAY_CYC cycles and then go to READY.
REQ-030 In SDRAM_INIT, LCD_REL or READY, lock_s=0 SHALL take the retry path, with priority over done_s and over counter expiry.
REQ-031 READY SHALL hold while lock_s=1.
REQ-032 Once READY is reached, a later drop of done_s SHALL be ignored.
REQ-033 On the retry path, retry_cnt SHALL increment, saturating at 15.
REQ-034 On the retry path, the next state SHALL be FAULT if the incremented value is >= MAX_RETRY, otherwise PLL_RST.
REQ-035 FAULT SHALL be terminal until rst_n=0.
REQ-036 retry_cnt SHALL hold its value across successful sequences; only rst_n clears it.

Reset
REQ-037 While rst_n=0 at an edge, the block SHALL set state=PLL_RST, counter=0, synchronizers=0, pll_rst=1, sdram_rst_n=0, lcd_rst_n=0, sys_ready=0, retry_cnt=0 and fault=0.
REQ-038 rst_n asserted in any state, including FAULT or mid-sequence, SHALL restart from PLL_RST with a full PLL_RST_CYC pulse.
REQ-039 The first PLL_RST cycle after rst_n rises SHALL count as cycle 0.

Verification
REQ-040 The bench SHALL use PLL_RST_CYC=4, LOCK_TIMEOUT_CYC=32, LOCK_STABLE_CYC=8, INIT_TIMEOUT_CYC=64, LCD_DELAY_CYC=4 and MAX_RETRY=3.
REQ-041 Nominal: pll_locked rises 10 cycles after rst_n deasserts; sdram_init_done rises 20 cycles after sdram_rst_n=1 -> required response:
- pll_rst high exactly 4 cycles
- sdram_rst_n rises 8 cycles after lock_s=1
- lcd_rst_n rises 2 cycles after sdram_init_done
- sys_ready rises 4 cycles later
- retry_cnt=0
REQ-042 Lock glitch in STABLE: pll_locked drops for 1 cycle at STABLE cycle 5 -> required response: returns to WAIT_LOCK; the stable count restarts for a full 8 cycles; retry_cnt=0; pll_rst not reasserted.
REQ-043 Lock loss in READY: pll_locked drops -> required response:
- 2 cycles later sys_ready=0, lcd_rst_n=0, sdram_rst_n=0 and pll_rst=1 on the same edge
- retry_cnt=1
- the sequence then completes normally after relock
REQ-044 Never lock: pll_locked held 0 -> required response: three 32-cycle WAIT_LOCK timeouts, then FAULT with fault=1, pll_rst=1, retry_cnt=3; the state stays in FAULT for 200+ cycles.
REQ-045 Simultaneous events: sdram_init_done is first seen in cycle 63 of SDRAM_INIT -> required response: LCD_REL, no retry. Separately, done_s and lock_s drop in the same cycle -> required response: retry path taken.
REQ-046 Mid-operation reset: rst_n pulsed low for 1 cycle during SDRAM_INIT with retry_cnt=2 -> required response: all outputs return to reset values, retry_cnt=0, fault=0, and a fresh 4-cycle pll_rst pulse follows.

Source files
------------

// File: rtl/rst_seq_ctrl.sv
// Power-up reset sequencer: pulses the PLL reset, waits for a stable lock,
// then releases the SDRAM controller and the LCD timing logic. Failed attempts are retried a bounded number of times.
module rst_seq_ctrl #(
  parameter int unsigned PLL_RST_CYC      = 16,
  parameter int unsigned LOCK_TIMEOUT_CYC = 50000,
  parameter int unsigned LOCK_STABLE_CYC  = 1000,
  parameter int unsigned INIT_TIMEOUT_CYC = 65535,
  parameter int unsigned LCD_DELAY_CYC    = 100,
  parameter int unsigned MAX_RETRY        = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       sdram_init_done,
  output logic       pll_rst,
  output logic       sdram_rst_n,
  output logic       lcd_rst_n,
  output logic       sys_ready,
  output logic [3:0] retry_cnt,
  output logic       fault
);

  localparam int unsigned CNT_W = 17;

  // Counter value seen in the last cycle of each timed state
  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYC - 1);
  localparam logic [CNT_W-1:0] LOCK_TO_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] INIT_TO_LAST = CNT_W'(INIT_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] LCD_LAST     = CNT_W'(LCD_DELAY_CYC - 1);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_SDRAM_INIT,
    S_LCD_REL,
    S_READY,
    S_FAULT
  } state_t;

  logic             lock_meta_reg;
  logic             lock_s_reg;
  logic             done_meta_reg;
  logic             done_s_reg;
  state_t           state_reg;
  state_t           state_next;
  state_t           retry_state;
  logic [CNT_W-1:0] cnt_reg;
  logic [3:0]       retry_cnt_reg;
  logic [3:0]       retry_next;
  logic [3:0]       retry_inc;
  logic             take_retry;
  logic             pll_rst_reg;
  logic             sdram_rst_n_reg;
  logic             lcd_rst_n_reg;
  logic             sys_ready_reg;
  logic             fault_reg;

  // Both status inputs come from other clock domains
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_meta_reg <= 1'b0;
      lock_s_reg    <= 1'b0;
      done_meta_reg <= 1'b0;
      done_s_reg    <= 1'b0;
    end else begin
      lock_meta_reg <= pll_locked;
      lock_s_reg    <= lock_meta_reg;
      done_meta_reg <= sdram_init_done;
      done_s_reg    <= done_meta_reg;
    end
  end

  always_comb begin
    retry_inc   = (retry_cnt_reg == 4'hF) ? 4'hF : retry_cnt_reg + 4'd1;
    retry_state = (retry_inc >= RETRY_LIMIT) ? S_FAULT : S_PLL_RST;
    take_retry  = 1'b0;
    state_next  = state_reg;
    case (state_reg)
      S_PLL_RST: begin
        if (cnt_reg == PLL_RST_LAST) state_next = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lock_s_reg) begin
          state_next = S_STABLE;
        end else if (cnt_reg == LOCK_TO_LAST) begin
          take_retry = 1'b1;
          state_next = retry_state;
        end
      end
      S_STABLE: begin
        if (!lock_s_reg) state_next = S_WAIT_LOCK;
        else if (cnt_reg == STABLE_LAST) state_next = S_SDRAM_INIT;
      end
      S_SDRAM_INIT: begin
        // Lock loss outranks both completion and timeout
        if (!lock_s_reg) begin
          take_retry = 1'b1;
          state_next = retry_state;
        end else if (done_s_reg) begin
          state_next = S_LCD_REL;
        end else if (cnt_reg == INIT_TO_LAST) begin
          take_retry = 1'b1;
          state_next = retry_state;
        end
      end
      S_LCD_REL: begin
        if (!lock_s_reg) begin
          take_retry = 1'b1;
          state_next = retry_state;
        end else if (cnt_reg == LCD_LAST) begin
          state_next = S_READY;
        end
      end
      S_READY: begin
        if (!lock_s_reg) begin
          take_retry = 1'b1;
          state_next = retry_state;
        end
      end
      S_FAULT:  state_next = S_FAULT;
      default:  state_next = S_PLL_RST;
    endcase
    retry_next = take_retry ? retry_inc : retry_cnt_reg;
  end

  // Outputs are decoded from the state being entered so they change on the transition edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= S_PLL_RST;
      cnt_reg         <= '0;
      retry_cnt_reg   <= 4'd0;
      pll_rst_reg     <= 1'b1;
      sdram_rst_n_reg <= 1'b0;
      lcd_rst_n_reg   <= 1'b0;
      sys_ready_reg   <= 1'b0;
      fault_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      retry_cnt_reg <= retry_next;
      if (state_next != state_reg) cnt_reg <= '0;
      else if (cnt_reg != '1) cnt_reg <= cnt_reg + 1'b1;
      pll_rst_reg     <= 1'b0;
      sdram_rst_n_reg <= 1'b0;
      lcd_rst_n_reg   <= 1'b0;
      sys_ready_reg   <= 1'b0;
      fault_reg       <= 1'b0;
      case (state_next)
        S_PLL_RST:    pll_rst_reg <= 1'b1;
        S_SDRAM_INIT: sdram_rst_n_reg <= 1'b1;
        S_LCD_REL: begin
          sdram_rst_n_reg <= 1'b1;
          lcd_rst_n_reg   <= 1'b1;
        end
        S_READY: begin
          sdram_rst_n_reg <= 1'b1;
          lcd_rst_n_reg   <= 1'b1;
          sys_ready_reg   <= 1'b1;
        end
        S_FAULT: begin
          pll_rst_reg <= 1'b1;
          fault_reg   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pll_rst     = pll_rst_reg;
  assign sdram_rst_n = sdram_rst_n_reg;
  assign lcd_rst_n   = lcd_rst_n_reg;
  assign sys_ready   = sys_ready_reg;
  assign retry_cnt   = retry_cnt_reg;
  assign fault       = fault_reg;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl with short timing parameters; cyc counts
// rising edges since rst_n was released, inputs and outputs handled 1 time unit after each edge.
module tb_rst_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       pll_locked;
  logic       sdram_init_done;
  logic       pll_rst;
  logic       sdram_rst_n;
  logic       lcd_rst_n;
  logic       sys_ready;
  logic [3:0] retry_cnt;
  logic       fault;

  int checks;
  int errors;
  int cyc;

  rst_seq_ctrl #(
    .PLL_RST_CYC     (4),
    .LOCK_TIMEOUT_CYC(32),
    .LOCK_STABLE_CYC (8),
    .INIT_TIMEOUT_CYC(64),
    .LCD_DELAY_CYC   (4),
    .MAX_RETRY       (3)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pll_locked     (pll_locked),
    .sdram_init_done(sdram_init_done),
    .pll_rst        (pll_rst),
    .sdram_rst_n    (sdram_rst_n),
    .lcd_rst_n      (lcd_rst_n),
    .sys_ready      (sys_ready),
    .retry_cnt      (retry_cnt),
    .fault          (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input logic lock_v, input logic done_v);
    rst_n           = 1'b0;
    pll_locked      = lock_v;
    sdram_init_done = done_v;
    repeat (3) step();
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  // Vector layout: {pll_rst, sdram_rst_n, lcd_rst_n, sys_ready, retry_cnt[3:0], fault}
  task automatic test_reset();
    logic [8:0] got;
    rst_n           = 1'b0;
    pll_locked      = 1'b1;
    sdram_init_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      got = {pll_rst, sdram_rst_n, lcd_rst_n, sys_ready, retry_cnt, fault};
      checks++;
      if (got !== 9'b1000_0000_0) begin
        errors++;
        $display("FAIL reset i=%0d got=%b exp=%b", i, got, 9'b1000_0000_0);
      end
    end
    $display("test_reset: checks=%0d errors=%0d", checks, errors);
  endtask

  // Lock 10 edges after release; done 20 edges after sdram_rst_n rises (edge 21)
  task automatic test_nominal();
    logic [8:0] got, exp;
    do_reset(1'b0, 1'b0);
    for (int i = 1; i <= 60; i++) begin
      step();
      exp = {cyc <= 3, cyc >= 21, cyc >= 44, cyc >= 48, 4'd0, 1'b0};
      got = {pll_rst, sdram_rst_n, lcd_rst_n, sys_ready, retry_cnt, fault};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL nominal cyc=%0d got=%b exp=%b", cyc, got, exp);
      end
      if (cyc == 10) pll_locked = 1'b1;
      if (cyc == 41) sdram_init_done = 1'b1;
    end
    $display("test_nominal: checks=%0d errors=%0d", checks, errors);
  endtask

  // Continues from READY: dropping done is ignored
  task automatic test_done_drop_ready();
    logic [8:0] got;
    sdram_init_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      got = {pll_rst, sdram_rst_n, lcd_rst_n, sys_ready, retry_cnt, fault};
      checks++;
      if (got !== 9'b0111_0000_0) begin
        errors++;
        $display("FAIL done_drop cyc=%0d got=%b exp=%b", cyc, got, 9'b0111_0000_0);
      end
    end
    $display("test_done_drop_ready: checks=%0d errors=%0d", checks, errors);
  endtask

  // Lock dropped after edge 70 -> retry at edge 73; relock and re-sequence to READY at edge 97
  task automatic test_lock_loss_ready();
    logic [8:0] got, exp;
    logic [3:0] rc;
    pll_locked = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      rc  = (cyc >= 73) ? 4'd1 : 4'd0;
      exp = {cyc >= 73 && cyc <= 76, cyc <= 72 || cyc >= 86,
             cyc <= 72 || cyc >= 93, cyc <= 72 || cyc >= 97, rc, 1'b0};
      got = {pll_rst, sdram_rst_n, lcd_rst_n, sys_ready, retry_cnt, fault};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL lock_loss cyc=%0d got=%b exp=%b", cyc, got, exp);
      end
      if (cyc == 73) pll_locked = 1'b1;
      if (cyc == 90) sdram_init_done = 1'b1;
    end
    $display("test_lock_loss_ready: checks=%0d errors=%0d", checks, errors);
  endtask

  // Locked from release: STABLE at edge 5, glitch hits STABLE cycle 5 -> WAIT_LOCK at 11,
  // STABLE again at 12, SDRAM_INIT at 20 (instead of 13).
  // done first seen in SDRAM_INIT cycle 63 -> LCD_REL at 84, READY at 88.
  // Then lock and done drop together -> retry at edge 93.
  task automatic test_glitch_and_simultaneous();
    logic [8:0] got, exp;
    logic [3:0] rc;
    do_reset(1'b1, 1'b0);
    for (int i = 1; i <= 96; i++) begin
      step();
      rc  = (cyc >= 93) ? 4'd1 : 4'd0;
      exp = {cyc <= 3 || cyc >= 93, cyc >= 20 && cyc <= 92,
             cyc >= 84 && cyc <= 92, cyc >= 88 && cyc <= 92, rc, 1'b0};
      got = {pll_rst, sdram_rst_n, lcd_rst_n, sys_ready, retry_cnt, fault};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL glitch_simul cyc=%0d got=%b exp=%b", cyc, got, exp);
      end
      if (cyc == 8)  pll_locked = 1'b0;
      if (cyc == 9)  pll_locked = 1'b1;
      if (cyc == 81) sdram_init_done = 1'b1;
      if (cyc == 90) begin
        pll_locked      = 1'b0;
        sdram_init_done = 1'b0;
      end
    end
    $display("test_glitch_and_simultaneous: checks=%0d errors=%0d", checks, errors);
  endtask

  // Three WAIT_LOCK timeouts at edges 36, 72, 108 -> FAULT; late lock must not leave FAULT
  task automatic test_never_lock();
    logic [8:0] got, exp;
    logic [3:0] rc;
    do_reset(1'b0, 1'b0);
    for (int i = 1; i <= 320; i++) begin
      step();
      rc  = (cyc >= 108) ? 4'd3 : (cyc >= 72) ? 4'd2 : (cyc >= 36) ? 4'd1 : 4'd0;
      exp = {cyc <= 3 || (cyc >= 36 && cyc <= 39) || (cyc >= 72 && cyc <= 75) || cyc >= 108,
             1'b0, 1'b0, 1'b0, rc, cyc >= 108};
      got = {pll_rst, sdram_rst_n, lcd_rst_n, sys_ready, retry_cnt, fault};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL never_lock cyc=%0d got=%b exp=%b", cyc, got, exp);
      end
      if (cyc == 150) pll_locked = 1'b1;
    end
    $display("test_never_lock: checks=%0d errors=%0d", checks, errors);
  endtask

  // Reset out of FAULT; two timeouts (retry=2), lock lands in the third timeout cycle
  // and wins (STABLE at 108, SDRAM_INIT at 116); 1-cycle rst_n pulse at edge 119.
  task automatic test_mid_reset();
    logic [8:0] got, exp;
    logic [3:0] rc;
    do_reset(1'b0, 1'b0);
    got = {pll_rst, sdram_rst_n, lcd_rst_n, sys_ready, retry_cnt, fault};
    checks++;
    if (got !== 9'b1000_0000_0) begin
      errors++;
      $display("FAIL fault_reset got=%b exp=%b", got, 9'b1000_0000_0);
    end
    for (int i = 1; i <= 119; i++) begin
      step();
      rc  = (cyc >= 119) ? 4'd0 : (cyc >= 72) ? 4'd2 : (cyc >= 36) ? 4'd1 : 4'd0;
      exp = {cyc <= 3 || (cyc >= 36 && cyc <= 39) || (cyc >= 72 && cyc <= 75) || cyc >= 119,
             cyc >= 116 && cyc <= 118, 1'b0, 1'b0, rc, 1'b0};
      got = {pll_rst, sdram_rst_n, lcd_rst_n, sys_ready, retry_cnt, fault};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL mid_reset cyc=%0d got=%b exp=%b", cyc, got, exp);
      end
      if (cyc == 105) pll_locked = 1'b1;
      if (cyc == 118) rst_n = 1'b0;
    end
    rst_n = 1'b1;
    cyc   = 0;
    for (int i = 1; i <= 6; i++) begin
      step();
      exp = {cyc <= 3, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
      got = {pll_rst, sdram_rst_n, lcd_rst_n, sys_ready, retry_cnt, fault};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL restart cyc=%0d got=%b exp=%b", cyc, got, exp);
      end
    end
    $display("test_mid_reset: checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    cyc             = 0;
    rst_n           = 1'b0;
    pll_locked      = 1'b0;
    sdram_init_done = 1'b0;
    test_reset();
    test_nominal();
    test_done_drop_ready();
    test_lock_loss_ready();
    test_glitch_and_simultaneous();
    test_never_lock();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
